// File: rtl/freq_meter.sv
// Gated-window frequency meter: counts synchronized rising edges of sig_in_i over
// GATE_CYCLES clocks, then latches the count into freq_o and pulses valid_o.
module freq_meter #(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sig_in_i,
  output logic [CNT_W-1:0] freq_o,
  output logic             valid_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [GATE_W-1:0]      gate_cnt_q;
  logic [CNT_W-1:0]       edge_cnt_q;
  logic                   sat_q;
  logic [CNT_W-1:0]       freq_q;
  logic                   ovf_q;
  logic                   valid_q;

  logic                   sig_s;
  logic                   rise;
  logic                   edge_max;
  logic                   gate_end;
  logic [CNT_W-1:0]       edge_cnt_d;
  logic                   sat_d;

  // Synchronizer chain: stage 0 takes the raw pin, last stage feeds edge detect.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) sync_q[0] <= 1'b0;
          else         sync_q[0] <= sig_in_i;
        end
      end else begin : g_rest
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) sync_q[gi] <= 1'b0;
          else         sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  // prev_q follows the synced signal in every state, so raising en_i with the
  // input already high does not produce a phantom edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b0;
    else         prev_q <= sig_s;
  end

  assign sig_s    = sync_q[SYNC_STAGES-1];
  assign rise     = sig_s & ~prev_q;
  assign edge_max = &edge_cnt_q;
  assign gate_end = (gate_cnt_q == GATE_LAST);

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    if (rise) begin
      if (edge_max) sat_d      = 1'b1;
      else          edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          gate_cnt_q <= '0;
          edge_cnt_q <= '0;
          sat_q      <= 1'b0;
          if (en_i) state_q <= MEASURE;
        end
        MEASURE: begin
          if (gate_end) begin
            // The end cycle's own edge still belongs to the closing window.
            freq_q     <= edge_cnt_d;
            ovf_q      <= sat_d;
            valid_q    <= 1'b1;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            state_q    <= en_i ? MEASURE : IDLE;
          end else if (!en_i) begin
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            state_q    <= IDLE;
          end else begin
            gate_cnt_q <= gate_cnt_q + GATE_W'(1);
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign freq_o  = freq_q;
  assign ovf_o   = ovf_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 32-bit and a 4-bit instance share all stimulus.
module tb_freq_meter;

  localparam int GATE = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sig;
  logic [31:0] freq;
  logic        valid, ovf, busy;
  logic [3:0]  freq4;
  logic        valid4, ovf4, busy4;

  int n_checks = 0;
  int n_pass   = 0;
  int half_per = 0;
  logic hold_val = 1'b0;

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(32), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .sig_in_i(sig),
    .freq_o(freq), .valid_o(valid), .ovf_o(ovf), .busy_o(busy)
  );

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .sig_in_i(sig),
    .freq_o(freq4), .valid_o(valid4), .ovf_o(ovf4), .busy_o(busy4)
  );

  always #5 clk = ~clk;

  // Stimulus source: half_per>0 toggles sig every half_per clocks, else holds hold_val.
  initial begin
    int cnt;
    cnt = 0;
    sig = 1'b0;
    forever begin
      @(negedge clk);
      if (half_per > 0) begin
        cnt++;
        if (cnt >= half_per) begin
          sig = ~sig;
          cnt = 0;
        end
      end else begin
        cnt = 0;
        sig = hold_val;
      end
    end
  end

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (valid !== 1'b1 && cycles <= budget);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0;
    half_per = 0;
    hold_val = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (freq !== 32'd0) $display("FAIL reset_freq got=%0d want=0", freq); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", valid); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b want=0", ovf); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
    $display("reset: freq=%0d valid=%b ovf=%b busy=%b", freq, valid, ovf, busy);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_period10();
    int cyc;
    half_per = 5;
    en = 1'b1;
    wait_valid(300, cyc);
    n_checks++; if (cyc > 300) $display("FAIL p10_first_valid got=timeout want=valid"); else n_pass++;
    for (int w = 0; w < 3; w++) begin
      wait_valid(300, cyc);
      n_checks++; if (cyc !== GATE) $display("FAIL p10_gap got=%0d want=%0d", cyc, GATE); else n_pass++;
      n_checks++; if (freq !== 32'd10) $display("FAIL p10_freq got=%0d want=10", freq); else n_pass++;
      n_checks++; if (ovf !== 1'b0) $display("FAIL p10_ovf got=%b want=0", ovf); else n_pass++;
      $display("period10 window %0d: gap=%0d freq=%0d ovf=%b", w, cyc, freq, ovf);
    end
  endtask

  task automatic test_hold();
    int cyc;
    en = 1'b0;
    half_per = 0;
    hold_val = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL hold_idle_busy got=%b want=0", busy); else n_pass++;
    n_checks++; if (freq !== 32'd10) $display("FAIL hold_abort_freq got=%0d want=10", freq); else n_pass++;
    en = 1'b1;
    wait_valid(300, cyc);
    n_checks++; if (cyc !== GATE + 1) $display("FAIL hold_latency got=%0d want=%0d", cyc, GATE + 1); else n_pass++;
    n_checks++; if (freq !== 32'd0) $display("FAIL hold_high_freq got=%0d want=0", freq); else n_pass++;
    $display("hold high: latency=%0d freq=%0d", cyc, freq);
    hold_val = 1'b0;
    for (int w = 0; w < 2; w++) begin
      wait_valid(300, cyc);
      n_checks++; if (freq !== 32'd0) $display("FAIL hold_freq got=%0d want=0", freq); else n_pass++;
      $display("hold window %0d: gap=%0d freq=%0d", w, cyc, freq);
    end
  endtask

  task automatic test_toggle();
    int cyc;
    half_per = 1;
    wait_valid(300, cyc);
    n_checks++; if (cyc > 300) $display("FAIL tog_first_valid got=timeout want=valid"); else n_pass++;
    for (int w = 0; w < 2; w++) begin
      wait_valid(300, cyc);
      n_checks++; if (cyc !== GATE) $display("FAIL tog_gap got=%0d want=%0d", cyc, GATE); else n_pass++;
      n_checks++; if (freq !== 32'd50) $display("FAIL tog_freq got=%0d want=50", freq); else n_pass++;
      n_checks++; if (ovf !== 1'b0) $display("FAIL tog_ovf got=%b want=0", ovf); else n_pass++;
      n_checks++; if (freq4 !== 4'd15) $display("FAIL cnt4_sat_freq got=%0d want=15", freq4); else n_pass++;
      n_checks++; if (ovf4 !== 1'b1) $display("FAIL cnt4_sat_ovf got=%b want=1", ovf4); else n_pass++;
      $display("toggle window %0d: gap=%0d freq=%0d freq4=%0d ovf4=%b", w, cyc, freq, freq4, ovf4);
    end
  endtask

  task automatic test_cnt4_recover();
    int cyc;
    half_per = 5;
    wait_valid(300, cyc);
    wait_valid(300, cyc);
    n_checks++; if (cyc !== GATE) $display("FAIL rec_gap got=%0d want=%0d", cyc, GATE); else n_pass++;
    n_checks++; if (freq4 !== 4'd10) $display("FAIL cnt4_rec_freq got=%0d want=10", freq4); else n_pass++;
    n_checks++; if (ovf4 !== 1'b0) $display("FAIL cnt4_rec_ovf got=%b want=0", ovf4); else n_pass++;
    n_checks++; if (freq !== 32'd10) $display("FAIL rec_freq got=%0d want=10", freq); else n_pass++;
    $display("cnt4 recover: freq4=%0d ovf4=%b freq=%0d", freq4, ovf4, freq);
  endtask

  task automatic test_abort();
    int cyc;
    int pulses;
    // Entered on the cycle right after a valid pulse, so the gate counter is 0 here.
    repeat (40) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b want=0", busy); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL abort_valid got=%b want=0", valid); else n_pass++;
    pulses = 0;
    repeat (150) begin
      @(negedge clk);
      if (valid === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) $display("FAIL abort_pulses got=%0d want=0", pulses); else n_pass++;
    n_checks++; if (freq !== 32'd10) $display("FAIL abort_hold_freq got=%0d want=10", freq); else n_pass++;
    $display("abort: busy=%b pulses=%0d freq=%0d", busy, pulses, freq);
    en = 1'b1;
    wait_valid(300, cyc);
    n_checks++; if (cyc !== GATE + 1) $display("FAIL reen_latency got=%0d want=%0d", cyc, GATE + 1); else n_pass++;
    n_checks++; if (freq !== 32'd10) $display("FAIL reen_freq got=%0d want=10", freq); else n_pass++;
    $display("re-enable: latency=%0d freq=%0d", cyc, freq);
  endtask

  task automatic test_async_reset();
    int cyc;
    repeat (60) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (freq !== 32'd0) $display("FAIL arst_freq got=%0d want=0", freq); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL arst_valid got=%b want=0", valid); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL arst_ovf got=%b want=0", ovf); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL arst_busy got=%b want=0", busy); else n_pass++;
    $display("async reset: freq=%0d valid=%b ovf=%b busy=%b", freq, valid, ovf, busy);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_valid(300, cyc);
    n_checks++; if (cyc !== GATE + 1) $display("FAIL arst_resume_latency got=%0d want=%0d", cyc, GATE + 1); else n_pass++;
    wait_valid(300, cyc);
    n_checks++; if (cyc !== GATE) $display("FAIL arst_gap got=%0d want=%0d", cyc, GATE); else n_pass++;
    n_checks++; if (freq !== 32'd10) $display("FAIL arst_freq_resume got=%0d want=10", freq); else n_pass++;
    $display("after reset: gap=%0d freq=%0d", cyc, freq);
  endtask

  initial begin
    test_reset();
    test_period10();
    test_hold();
    test_toggle();
    test_cnt4_recover();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
